// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, status bits, FSM states and divider helpers for uart_mmio
package uart_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;

    localparam int ST_TX_READY   = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_TX_DROP    = 4;
    localparam int ST_TX_IDLE    = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Clocks per bit, truncated.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Width of a counter that runs 0 .. div-1.
    function automatic int calc_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// rtl/uart_mmio_if.sv - CPU data bus (ce/we/addr/data/sel) seen by uart_mmio
interface uart_mmio_if;
    logic        ce_i;
    logic        we_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic [31:0] data_o;

    modport master (output ce_i, we_i, addr_i, data_i, sel_i, input data_o);
    modport slave  (input ce_i, we_i, addr_i, data_i, sel_i, output data_o);
endinterface

// File: rtl/uart_mmio_sync_fifo.sv
// rtl/uart_mmio_sync_fifo.sv - single-clock FIFO used for the UART TX and RX queues
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             pop_eff;
    logic             push_eff;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    // A pop on empty is ignored; a push on full only lands if a pop frees the slot.
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_eff) wptr <= wptr + 1'b1;
            if (pop_eff)  rptr <= rptr + 1'b1;
            if (push_eff && !pop_eff)      count <= count + 1'b1;
            else if (!push_eff && pop_eff) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_eff) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - bus-attached 8N1 UART with TX/RX FIFOs, sticky flags and RX interrupt
module uart_mmio
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 10_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    uart_mmio_if.slave  bus,
    input  logic        rxd,
    output logic        txd,
    output logic        irq_o
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = calc_cnt_w(DIV);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DIV_M1  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

    // Bus decode
    logic data_wr, stat_wr, data_rd, any_rd;
    assign any_rd  = bus.ce_i & ~bus.we_i;
    assign data_wr = bus.ce_i & bus.we_i & (bus.addr_i == REG_DATA) & bus.sel_i[0];
    assign stat_wr = bus.ce_i & bus.we_i & (bus.addr_i == REG_STATUS);
    assign data_rd = any_rd & (bus.addr_i == REG_DATA);

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.data_i[31:8], bus.sel_i[3:1]};

    // FIFOs
    logic          tx_pop, tx_full, tx_empty, rx_push, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic [7:0]    tx_head, rx_head;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(data_wr), .push_data(bus.data_i[7:0]),
        .pop(tx_pop), .full(tx_full), .empty(tx_empty), .count(tx_count), .head(tx_head)
    );

    // TX FSM
    tx_state_t        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_idx, tx_idx_n;
    logic [7:0]       tx_shift, tx_shift_n;
    logic             tx_bit;

    // TX state, bit timer and txd register (txd lags the state by one cycle).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            txd      <= tx_bit;
        end
    end

    // TX next state: each state holds DIV cycles; STOP chains straight into START when more data waits.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        tx_bit     = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                tx_bit = 1'b0;
                if (tx_cnt == DIV_M1) begin
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_bit = tx_shift[tx_idx];
                if (tx_cnt == DIV_M1) begin
                    tx_cnt_n = '0;
                    if (tx_idx == 3'd7) tx_state_n = TX_STOP;
                    else                tx_idx_n   = tx_idx + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == DIV_M1) begin
                    tx_cnt_n = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_head;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .push_data(rx_shift),
        .pop(data_rd), .full(rx_full), .empty(rx_empty), .count(rx_count), .head(rx_head)
    );

    // RX synchroniser plus one extra stage for falling-edge detection; idles high so reset never fakes an edge.
    logic rx_s1, rx_s2, rx_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX FSM
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_idx, rx_idx_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             rx_ferr_set;

    // RX state and sampling registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
        end
    end

    // RX next state: half-bit start check rejects glitches, then one sample per bit period.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt + 1'b1;
        rx_idx_n    = rx_idx;
        rx_shift_n  = rx_shift;
        rx_push     = 1'b0;
        rx_ferr_set = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == DIV_M1) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    if (rx_idx == 3'd7) rx_state_n = RX_STOP;
                    else                rx_idx_n   = rx_idx + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == DIV_M1) begin
                    rx_cnt_n    = '0;
                    rx_state_n  = RX_IDLE;
                    rx_push     = rx_s2;
                    rx_ferr_set = ~rx_s2;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    logic rx_overrun, frame_err, tx_drop;
    logic ovr_set, drop_set;
    assign ovr_set  = rx_push & rx_full & ~data_rd;
    assign drop_set = data_wr & tx_full & ~tx_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            rx_overrun <= ovr_set     | (rx_overrun & ~(stat_wr & bus.data_i[ST_RX_OVERRUN]));
            frame_err  <= rx_ferr_set | (frame_err  & ~(stat_wr & bus.data_i[ST_FRAME_ERR]));
            tx_drop    <= drop_set    | (tx_drop    & ~(stat_wr & bus.data_i[ST_TX_DROP]));
        end
    end

    logic [5:0] status;
    always_comb begin
        status                = '0;
        status[ST_TX_READY]   = ~tx_full;
        status[ST_RX_VALID]   = ~rx_empty;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_FRAME_ERR]  = frame_err;
        status[ST_TX_DROP]    = tx_drop;
        status[ST_TX_IDLE]    = (tx_count == '0) && (tx_state == TX_IDLE);
    end

    // Registered read data (held across writes) and level interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_o <= '0;
            irq_o      <= 1'b0;
        end else begin
            irq_o <= (rx_count != '0);
            if (any_rd) begin
                case (bus.addr_i)
                    REG_DATA:   bus.data_o <= rx_empty ? 32'h0 : {24'h0, rx_head};
                    REG_STATUS: bus.data_o <= {26'h0, status};
                    default:    bus.data_o <= 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - scoreboard bench for uart_mmio against a queue-based UART model
module tb_uart_mmio;

    localparam int DIV   = 10;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic txd, irq_o;

    uart_mmio_if bus();

    uart_mmio #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .rxd(rxd), .txd(txd), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    bit chk_latency = 0;
    bit rst_seen = 0;
    bit rd_flag = 0;

    logic [31:0] exp_rd_q[$];
    logic [7:0]  exp_tx_q[$];
    int          fall_q[$];

    logic [7:0] m_rx[$];
    bit m_ovr = 0, m_ferr = 0, m_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status(input bit tx_ready, input bit tx_idle);
        return {26'h0, tx_idle, m_drop, m_ferr, m_ovr, (m_rx.size() != 0), tx_ready};
    endfunction

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_flag <= bus.ce_i && !bus.we_i;
    end

    always @(negedge rst_n) rst_seen = 1;

    // Read monitor: data_o is due the cycle after each read strobe.
    always @(negedge clk) begin
        if (rd_flag) begin
            if (exp_rd_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL bus_read_unexpected: got 0x%0h with no read pending", bus.data_o);
            end else begin
                check("bus_read", bus.data_o, exp_rd_q.pop_front());
            end
        end
    end

    // TX monitor: decode each frame on txd mid-bit and compare against accepted writes.
    initial begin : tx_mon
        logic [7:0] b;
        bit ok_start, ok_stop;
        int fc;
        forever begin
            @(negedge clk);
            if (rst_n && txd === 1'b0) begin
                fc = cyc;
                rst_seen = 0;
                repeat (DIV/2 - 1) @(negedge clk);
                ok_start = (txd === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                ok_stop = (txd === 1'b1);
                if (!rst_seen) begin
                    fall_q.push_back(fc);
                    check("tx_start_bit", 32'(ok_start), 32'd1);
                    check("tx_stop_bit", 32'(ok_stop), 32'd1);
                    if (exp_tx_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL tx_unexpected_frame: got 0x%0h with none expected", b);
                    end else begin
                        check("tx_byte", 32'(b), 32'(exp_tx_q.pop_front()));
                    end
                    if (chk_latency) begin
                        chk_latency = 0;
                        check("tx_latency", 32'(fc - last_wr_cyc), 32'd2);
                    end
                end
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.data_i = d; bus.sel_i = s;
        @(posedge clk);
        @(negedge clk);
        bus.ce_i = 1'b0; bus.we_i = 1'b0;
        last_wr_cyc = cyc;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a; bus.data_i = 32'($urandom); bus.sel_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.ce_i = 1'b0;
    endtask

    task automatic read_data_model();
        logic [31:0] e;
        e = (m_rx.size() != 0) ? {24'h0, m_rx.pop_front()} : 32'h0;
        bus_read(4'h0, e);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
        if (!stop)                   m_ferr = 1;
        else if (m_rx.size() < DEPTH) m_rx.push_back(b);
        else                          m_ovr = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [7:0] bb[6];
        bus.ce_i = 0; bus.we_i = 0; bus.addr_i = 0; bus.data_i = 0; bus.sel_i = 0;
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_irq", 32'(irq_o), 32'd0);
        check("reset_data_o", bus.data_o, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(4'h4, m_status(1, 1));

        // Single byte: latency, bit order, idle afterwards
        exp_tx_q.push_back(8'hA5);
        chk_latency = 1;
        bus_write(4'h0, 32'h0000_00A5, 4'h1);
        repeat (110) @(negedge clk);
        bus_read(4'h4, m_status(1, 1));

        // Burst of 6 writes: first goes to the shifter, next 4 fill the FIFO, 6th dropped
        fall_q.delete();
        for (int i = 0; i < 6; i++) bb[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) exp_tx_q.push_back(bb[i]);
        for (int i = 0; i < 6; i++)
            bus_write(4'h0, {24'($urandom), bb[i]}, 4'h1 | 4'($urandom));
        m_drop = 1;
        bus_read(4'h4, m_status(0, 0));
        bus_write(4'h4, 32'h10, 4'hF);
        m_drop = 0;
        bus_write(4'h0, 32'h77, 4'hE);
        bus_read(4'h4, m_status(0, 0));
        repeat (560) @(negedge clk);
        check("burst_frames", 32'(fall_q.size()), 32'd5);
        for (int i = 1; i < fall_q.size(); i++)
            check("burst_gap", 32'(fall_q[i] - fall_q[i-1]), 32'(10 * DIV));
        bus_read(4'h4, m_status(1, 1));

        // Single received byte and the interrupt around it
        send_rx(8'h3C, 1);
        repeat (2) @(negedge clk);
        check("irq_rise", 32'(irq_o), 32'd1);
        bus_read(4'h4, m_status(1, 1));
        read_data_model();
        @(negedge clk);
        check("irq_fall", 32'(irq_o), 32'd0);

        // Random bursts of frames, first one overflowing the RX FIFO
        for (int it = 0; it < 4; it++) begin
            int n;
            n = (it == 0) ? 5 : int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) send_rx(8'($urandom), 1);
            bus_read(4'h4, m_status(1, 1));
            for (int k = 0; k <= n; k++) read_data_model();
            bus_write(4'h4, 32'h1C, 4'hF);
            m_ovr = 0; m_ferr = 0; m_drop = 0;
            bus_read(4'h4, m_status(1, 1));
        end

        // Bad stop bit, then a short glitch
        send_rx(8'($urandom), 0);
        repeat (5) @(negedge clk);
        bus_read(4'h4, m_status(1, 1));
        bus_write(4'h4, 32'h08, 4'h1);
        m_ferr = 0;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(4'h4, m_status(1, 1));

        // Reset in the middle of a TX frame with a byte sitting in the RX FIFO
        send_rx(8'h5A, 1);
        exp_tx_q.push_back(8'($urandom));
        bus_write(4'h0, {24'h0, exp_tx_q[0]}, 4'h1);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid_txd", 32'(txd), 32'd1);
        check("reset_mid_irq", 32'(irq_o), 32'd0);
        exp_tx_q.delete();
        m_rx.delete();
        m_ovr = 0; m_ferr = 0; m_drop = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(4'h4, m_status(1, 1));
        bus_read(4'h0, 32'h0);

        repeat (120) @(negedge clk);
        check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
